// File: rtl/bk_pkg.sv
// ============================================================================
// Module   : bk_pkg
// Brief    : Shared types, level/rank helpers and saturation constants for
//            the Brent-Kung pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Saturation limits at maximum width; shifted down to the working width.
    localparam logic [63:0] c_sat_max64 = 64'h7FFF_FFFF_FFFF_FFFF;

    function automatic int bk_log2(input int width);
        int n;
        n = 0;
        while ((1 << n) < width) n++;
        return n;
    endfunction

    function automatic int bk_levels(input int width);
        return 2 * bk_log2(width) - 1;
    endfunction

    // Level after which register rank k sits: ceil(k*L/S).
    function automatic int bk_rank_level(input int k, input int lvl_l, input int stages);
        return (k * lvl_l + stages - 1) / stages;
    endfunction

    function automatic int bk_rank_index(input int lvl, input int lvl_l, input int stages);
        int res;
        res = 0;
        for (int k = 1; k <= stages; k++)
            if (bk_rank_level(k, lvl_l, stages) == lvl) res = k;
        return res;
    endfunction

    // Low-side partner of bit i at prefix level lvl, or -1 when the bit passes through.
    // Levels 1..n are the up-sweep, n+1..2n-1 the down-sweep.
    function automatic int bk_lo_index(input int lvl, input int i, input int n);
        int s;
        int res;
        res = -1;
        if (lvl <= n) begin
            s = 1 << lvl;
            if (((i + 1) % s) == 0) res = i - s / 2;
        end else begin
            s = 1 << (2 * n - lvl);
            if ((((i + 1) % s) == s / 2) && ((i + 1) > s)) res = i - s / 2;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bk_gp_cell.sv
// ============================================================================
// Module   : bk_gp_cell
// Brief    : Brent-Kung prefix operator combining a high and a low (g,p) group.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bk_gp_cell
    import bk_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t res
);

    assign res.g = hi.g | (hi.p & lo.g);
    assign res.p = hi.p & lo.p;

endmodule

`default_nettype wire

// File: rtl/bk_adder_pipe.sv
// ============================================================================
// Module   : bk_adder_pipe
// Brief    : Pipelined Brent-Kung adder/subtractor with valid/ready on both
//            sides. Define BKADD_SAT_EN for signed overflow and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef BKADD_SAT_EN
    ,
    output logic             overflow
`endif
);

    localparam int c_log2w = bk_log2(WIDTH);
    localparam int c_lvl_l = bk_levels(WIDTH) + 1;
`ifdef BKADD_SAT_EN
    localparam int c_aux_w = WIDTH + 3;
`else
    localparam int c_aux_w = WIDTH + 1;
`endif

    // ------------------------------------------------------------------
    // Valid/ready chain
    // ------------------------------------------------------------------
    logic [STAGES:1]   r_vld;
    logic [STAGES+1:1] w_rdy;
    logic [STAGES:1]   w_load;
    logic [STAGES:0]   w_vin;

    assign w_vin           = {r_vld, in_valid};
    assign w_rdy[STAGES+1] = out_ready;

    for (genvar k = 1; k <= STAGES; k++) begin : g_flow
        assign w_rdy[k]  = ~r_vld[k] | w_rdy[k+1];
        assign w_load[k] = w_vin[k-1] & w_rdy[k];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_vld <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++)
                if (w_rdy[k]) r_vld[k] <= w_vin[k-1];
        end
    end

    assign in_ready  = RST_N & w_rdy[1];
    assign out_valid = r_vld[STAGES];

    // ------------------------------------------------------------------
    // Operand conditioning (level 0)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_yg   [0:c_lvl_l-1];
    logic [WIDTH-1:0]   w_yp   [0:c_lvl_l-1];
    logic [c_aux_w-1:0] w_yaux [0:c_lvl_l-1];
    logic [WIDTH-1:0]   w_xg   [1:c_lvl_l];
    logic [WIDTH-1:0]   w_xp   [1:c_lvl_l];
    logic [c_aux_w-1:0] w_xaux [1:c_lvl_l];

    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    assign w_bx = sub ? ~b : b;
    assign w_c0 = sub | Cin;

    // Carry-in folded into bit 0 generate, so every G[i:0] is already the carry into bit i+1.
    assign w_yg[0] = {a[WIDTH-1:1] & w_bx[WIDTH-1:1],
                      (a[0] & w_bx[0]) | ((a[0] ^ w_bx[0]) & w_c0)};
    assign w_yp[0] = a ^ w_bx;
`ifdef BKADD_SAT_EN
    assign w_yaux[0] = {a[WIDTH-1], w_bx[WIDTH-1], w_c0, a ^ w_bx};
`else
    assign w_yaux[0] = {w_c0, a ^ w_bx};
`endif

    // ------------------------------------------------------------------
    // Prefix levels 1..L-1
    // ------------------------------------------------------------------
    for (genvar l = 1; l < c_lvl_l; l++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam int c_lo = bk_lo_index(l, i, c_log2w);
            if (c_lo >= 0) begin : g_cell
                gp_t w_hi;
                gp_t w_lo;
                gp_t w_res;
                assign w_hi = {w_xg[l][i], w_xp[l][i]};
                assign w_lo = {w_xg[l][c_lo], w_xp[l][c_lo]};
                bk_gp_cell u_cell (
                    .hi  (w_hi),
                    .lo  (w_lo),
                    .res (w_res)
                );
                assign w_yg[l][i] = w_res.g;
                assign w_yp[l][i] = w_res.p;
            end else begin : g_pass
                assign w_yg[l][i] = w_xg[l][i];
                assign w_yp[l][i] = w_xp[l][i];
            end
        end
        assign w_yaux[l] = w_xaux[l];
    end

    // ------------------------------------------------------------------
    // Inter-level pipeline ranks 1..STAGES-1
    // ------------------------------------------------------------------
    for (genvar l = 0; l < c_lvl_l; l++) begin : g_pipe
        localparam int c_k = bk_rank_index(l, c_lvl_l, STAGES);
        if (c_k != 0) begin : g_rank
            logic [WIDTH-1:0]   r_g;
            logic [WIDTH-1:0]   r_p;
            logic [c_aux_w-1:0] r_aux;
            // Loads only on a real transfer, so a stalled rank keeps its beat.
            always_ff @(posedge CLK) begin
                if (w_load[c_k]) begin
                    r_g   <= w_yg[l];
                    r_p   <= w_yp[l];
                    r_aux <= w_yaux[l];
                end
            end
            assign w_xg[l+1]   = r_g;
            assign w_xp[l+1]   = r_p;
            assign w_xaux[l+1] = r_aux;
        end else begin : g_wire
            assign w_xg[l+1]   = w_yg[l];
            assign w_xp[l+1]   = w_yp[l];
            assign w_xaux[l+1] = w_yaux[l];
        end
    end

    // ------------------------------------------------------------------
    // Sum XOR level and output rank
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout;

    assign w_carry = {w_xg[c_lvl_l][WIDTH-2:0], w_xaux[c_lvl_l][WIDTH]};
    assign w_raw   = w_xaux[c_lvl_l][WIDTH-1:0] ^ w_carry;
    assign w_cout  = w_xg[c_lvl_l][WIDTH-1];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

`ifdef BKADD_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_max = WIDTH'(c_sat_max64 >> (64 - WIDTH));
    localparam logic [WIDTH-1:0] c_sat_min = ~c_sat_max;

    logic w_am;
    logic w_bm;
    logic w_ovf;
    logic r_ovf;

    assign w_am      = w_xaux[c_lvl_l][WIDTH+2];
    assign w_bm      = w_xaux[c_lvl_l][WIDTH+1];
    assign w_ovf     = (w_am == w_bm) & (w_raw[WIDTH-1] != w_am);
    assign w_sum_nxt = w_ovf ? (w_am ? c_sat_min : c_sat_max) : w_raw;

    always_ff @(posedge CLK) begin
        if (!RST_N)                r_ovf <= 1'b0;
        else if (w_load[STAGES])   r_ovf <= w_ovf;
    end

    assign overflow = r_ovf;
`else
    assign w_sum_nxt = w_raw;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load[STAGES]) begin
            r_sum  <= w_sum_nxt;
            r_cout <= w_cout;
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
// ============================================================================
// Module   : tb_bk_adder_pipe
// Brief    : Directed self-checking bench: 16-bit/2-stage and 32-bit/4-stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bk_adder_pipe;

    logic        CLK;
    logic        RST_N;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        Cin, sub, carry_out;
`ifdef BKADD_SAT_EN
    logic        overflow;
`endif

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, sum32;
    logic        cin32, sub32, carry_out32;
`ifdef BKADD_SAT_EN
    logic        overflow32;
`endif

    int n_checks;
    int n_errors;

    bk_adder_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef BKADD_SAT_EN
        ,
        .overflow  (overflow)
`endif
    );

    bk_adder_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .Cin       (cin32),
        .sub       (sub32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .sum       (sum32),
        .carry_out (carry_out32)
`ifdef BKADD_SAT_EN
        ,
        .overflow  (overflow32)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
        in_valid = 1'b1;
        a = av;
        b = bv;
        Cin = ci;
        sub = sb;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST_N = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {48'd0, sum}, 64'd0);
        chk("rst_carry", {63'd0, carry_out}, 64'd0);
        RST_N = 1'b1;
        tick();
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back adds, latency 2
        drive(16'h3DAC, 16'h43CD, 1'b0, 1'b0);
        tick();
        chk("t1_not_yet", {63'd0, out_valid}, 64'd0);
        drive(16'hA843, 16'hCD45, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_sum", {48'd0, sum}, 64'h8179);
        chk("t1_carry", {63'd0, carry_out}, 64'd0);
        tick();
        chk("t2_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_sum", {48'd0, sum}, 64'h7589);
        chk("t2_carry", {63'd0, carry_out}, 64'd1);
        tick();
        chk("t2_drained", {63'd0, out_valid}, 64'd0);

        // Subtract with borrow; Cin must be ignored
        drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        tick();
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3a_sum", {48'd0, sum}, 64'hFFFE);
        chk("t3a_carry", {63'd0, carry_out}, 64'd0);
        tick();
        chk("t3b_valid", {63'd0, out_valid}, 64'd1);
        chk("t3b_sum", {48'd0, sum}, 64'hFFFE);
        chk("t3b_carry", {63'd0, carry_out}, 64'd0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        drive(16'hFFFF, 16'h0002, 1'b0, 1'b0);
        chk("t4_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("t4_head_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_head_sum", {48'd0, sum}, 64'h0002);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("t4_hold_sum", {48'd0, sum}, 64'h0002);
            chk("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_r2_sum", {48'd0, sum}, 64'h2345);
        chk("t4_r2_carry", {63'd0, carry_out}, 64'd0);
        tick();
        chk("t4_r3_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_r3_sum", {48'd0, sum}, 64'h0001);
        chk("t4_r3_carry", {63'd0, carry_out}, 64'd1);
        tick();
        chk("t4_no_dup", {63'd0, out_valid}, 64'd0);

        // Reset with two beats in flight
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(16'h3333, 16'h4444, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("t5_in_ready_low", {63'd0, in_ready}, 64'd0);
        tick();
        chk("t5_valid_clr", {63'd0, out_valid}, 64'd0);
        chk("t5_sum_clr", {48'd0, sum}, 64'd0);
        RST_N = 1'b1;
        tick();
        chk("t5_no_stale1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("t5_no_stale2", {63'd0, out_valid}, 64'd0);

        // Signed overflow cases
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h8000, 16'h0001, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
`ifdef BKADD_SAT_EN
        chk("t6a_ovf", {63'd0, overflow}, 64'd1);
        chk("t6a_sum", {48'd0, sum}, 64'h7FFF);
`else
        chk("t6a_sum", {48'd0, sum}, 64'h8000);
`endif
        chk("t6a_carry", {63'd0, carry_out}, 64'd0);
        tick();
`ifdef BKADD_SAT_EN
        chk("t6b_ovf", {63'd0, overflow}, 64'd1);
        chk("t6b_sum", {48'd0, sum}, 64'h8000);
`else
        chk("t6b_sum", {48'd0, sum}, 64'h7FFF);
`endif
        chk("t6b_carry", {63'd0, carry_out}, 64'd1);
        tick();

        // 32-bit, 4 stages: full carry ripple, latency 4
        in_valid32 = 1'b1;
        a32 = 32'hFFFF_FFFF;
        b32 = 32'h0000_0000;
        cin32 = 1'b1;
        sub32 = 1'b0;
        tick();
        in_valid32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6w_latency_wait", {63'd0, out_valid32}, 64'd0);
            tick();
        end
        chk("t6w_valid", {63'd0, out_valid32}, 64'd1);
        chk("t6w_sum", {32'd0, sum32}, 64'd0);
        chk("t6w_carry", {63'd0, carry_out32}, 64'd1);
        tick();
        chk("t6w_drained", {63'd0, out_valid32}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
